// File: rtl/led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO: word address, select, write strobe and data.
interface led_pio_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pio_blink.sv
// Avalon-MM LED output port: DATA with atomic set/clear, per-bit blinking from a prescaled tick.
// Optional one-shot pulse register at address 6 when LED_PIO_PULSE_EN is defined.
module led_pio_blink #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      PRESCALE    = 50000,
    parameter int unsigned      PERIOD_W    = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      PULSE_TICKS = 16
) (
    input  logic              clk,
    input  logic              reset,
    led_pio_blink_if.slave    bus,
    output logic [WIDTH-1:0]  out_port
);
    localparam int unsigned     PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_BLINK  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;
    localparam logic [2:0] ADDR_PULSE  = 3'd6;

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    blink_q;
    logic [WIDTH-1:0]    pulse_bit;
    logic [WIDTH-1:0]    pulse_rd;
    logic [WIDTH-1:0]    wd;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] blk_cnt_q;
    logic [PS_W-1:0]     ps_cnt_q;
    logic                phase_q;
    logic                tick;
    logic                wr_en;
    logic                unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign tick      = (ps_cnt_q == PS_LAST);
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            blink_q <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:  data_q  <= wd;
                ADDR_SET:   data_q  <= data_q | wd;
                ADDR_CLR:   data_q  <= data_q & ~wd;
                ADDR_BLINK: blink_q <= wd;
                default: ;
            endcase
        end
    end

    // A PERIOD write restarts the whole timebase and wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q  <= '0;
            ps_cnt_q  <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
        end else if (wr_en && bus.address == ADDR_PERIOD) begin
            period_q  <= bus.writedata[PERIOD_W-1:0];
            ps_cnt_q  <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
        end else begin
            ps_cnt_q <= tick ? '0 : ps_cnt_q + PS_W'(1);
            if (period_q == '0) begin
                blk_cnt_q <= '0;
                phase_q   <= 1'b1;
            end else if (tick) begin
                if (blk_cnt_q == period_q - PERIOD_W'(1)) begin
                    blk_cnt_q <= '0;
                    phase_q   <= ~phase_q;
                end else begin
                    blk_cnt_q <= blk_cnt_q + PERIOD_W'(1);
                end
            end
        end
    end

`ifdef LED_PIO_PULSE_EN
    localparam int unsigned PC_W = $clog2(PULSE_TICKS + 1);

    logic [WIDTH-1:0] pulse_mask_q;
    logic [PC_W-1:0]  pulse_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_mask_q <= '0;
            pulse_cnt_q  <= '0;
        end else if (wr_en && bus.address == ADDR_PULSE) begin
            pulse_mask_q <= wd;
            pulse_cnt_q  <= PC_W'(PULSE_TICKS);
        end else if (tick && pulse_cnt_q != '0) begin
            pulse_cnt_q <= pulse_cnt_q - PC_W'(1);
            if (pulse_cnt_q == PC_W'(1)) begin
                pulse_mask_q <= '0;
            end
        end
    end

    assign pulse_bit = (pulse_cnt_q != '0) ? pulse_mask_q : '0;
    assign pulse_rd  = pulse_mask_q;
`else
    assign pulse_bit = '0;
    assign pulse_rd  = '0;
`endif

    assign out_port = (data_q & (~blink_q | {WIDTH{phase_q}})) | pulse_bit;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata[WIDTH-1:0]    = data_q;
            ADDR_SET:    bus.readdata[WIDTH-1:0]    = out_port;
            ADDR_BLINK:  bus.readdata[WIDTH-1:0]    = blink_q;
            ADDR_PERIOD: bus.readdata[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: bus.readdata[0]            = phase_q;
            ADDR_PULSE:  bus.readdata[WIDTH-1:0]    = pulse_rd;
            default: ;
        endcase
    end
endmodule
